// File: rtl/clk_div_pkg.sv
// Shared definitions for the integer clock divider.
// Holds the 2-bit state encoding and the default ratio width.
package clk_div_pkg;

    localparam int unsigned RATIO_WD_DEF = 8;
    localparam int unsigned STATE_WD     = 2;

    typedef enum logic [STATE_WD-1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } clk_div_state_e;

endpackage : clk_div_pkg

// File: rtl/mux2X1.sv
// 2:1 clock mux cell. All clock-path muxing goes through this cell.
// Ports:
//   Function_mode - functional-path input, selected when sel=0
//   Test_mode     - alternate-path input, selected when sel=1
//   sel           - select
//   mux_out       - muxed output
module mux2X1 (
    input  logic Function_mode,
    input  logic Test_mode,
    input  logic sel,
    output logic mux_out
);

    assign mux_out = sel ? Test_mode : Function_mode;

endmodule : mux2X1

// File: rtl/clk_div_int.sv
// Integer clock divider with glitch-free ratio changes and bypass.
// Ports:
//   i_ref_clk   - muxed reference clock, all state on its rising edge
//   i_rst_n     - asynchronous active-low reset
//   i_clk_en    - division enable
//   i_div_ratio - division ratio N (0/1 = bypass)
//   o_div_clk   - divided clock, or i_ref_clk in bypass
//   o_tick      - one-ref-cycle pulse on each divided-clock rising edge
//   o_active    - high while the FSM is not idle
module clk_div_int
    import clk_div_pkg::*;
#(
    parameter int unsigned RATIO_WD = RATIO_WD_DEF
) (
    input  logic                i_ref_clk,
    input  logic                i_rst_n,
    input  logic                i_clk_en,
    input  logic [RATIO_WD-1:0] i_div_ratio,
    output logic                o_div_clk,
    output logic                o_tick,
    output logic                o_active
);

    clk_div_state_e      state_q,   state_d;
    logic [RATIO_WD-1:0] cnt_q,     cnt_d;
    logic [RATIO_WD-1:0] ratio_l_q, ratio_l_d;
    logic                div_r_q,   div_r_d;
    logic                tick_q,    tick_d;
    logic                active_q,  active_d;

    logic                active_req_c;
    logic [RATIO_WD-1:0] hi_new_c;
    logic [RATIO_WD-1:0] lo_cur_c;
    logic                bypass_c;

    // Division requested: enabled with a ratio of at least 2.
    assign active_req_c = i_clk_en && (i_div_ratio >= RATIO_WD'(2));

    // High phase of a period about to start comes from the live ratio;
    // low phase of the running period comes from the latched ratio.
    assign hi_new_c = i_div_ratio >> 1;
    assign lo_cur_c = ratio_l_q - (ratio_l_q >> 1);

    // State and datapath registers.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ratio_l_q <= '0;
            div_r_q   <= 1'b0;
            tick_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ratio_l_q <= ratio_l_d;
            div_r_q   <= div_r_d;
            tick_q    <= tick_d;
            active_q  <= active_d;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ratio_l_d = ratio_l_q;
        div_r_d   = div_r_q;
        tick_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                div_r_d = 1'b0;
                if (active_req_c) begin
                    state_d   = ST_HIGH;
                    ratio_l_d = i_div_ratio;
                    div_r_d   = 1'b1;
                    cnt_d     = hi_new_c - RATIO_WD'(1);
                    tick_d    = 1'b1;
                end
            end
            ST_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = ST_LOW;
                    div_r_d = 1'b0;
                    cnt_d   = lo_cur_c - RATIO_WD'(1);
                end else begin
                    cnt_d = cnt_q - RATIO_WD'(1);
                end
            end
            ST_LOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - RATIO_WD'(1);
                end else if (active_req_c) begin
                    // Period boundary: only point where a new ratio is taken.
                    state_d   = ST_HIGH;
                    ratio_l_d = i_div_ratio;
                    div_r_d   = 1'b1;
                    cnt_d     = hi_new_c - RATIO_WD'(1);
                    tick_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                div_r_d = 1'b0;
            end
        endcase

        active_d = (state_d != ST_IDLE);
    end

    // Bypass while in reset, or idle with no division requested.
    assign bypass_c = !i_rst_n || ((state_q == ST_IDLE) && !active_req_c);

    // Output clock select through the shared clock mux cell.
    mux2X1 u_bypass_mux (
        .Function_mode (div_r_q),
        .Test_mode     (i_ref_clk),
        .sel           (bypass_c),
        .mux_out       (o_div_clk)
    );

    assign o_tick   = tick_q;
    assign o_active = active_q;

endmodule : clk_div_int

// File: doc/clk_div_int.md
# clk_div_int

Integer clock divider for the low-power multi-clock system, generating UART-side and peripheral clocks from the reference clock. It sits directly downstream of the DFT clock/reset select muxes and consumes the muxed reference clock and reset. It produces a divided clock with a programmable ratio and glitch-free ratio changes, plus a bypass path when division is disabled.

## Interface
- `RATIO_WD`, default 8: width of the division ratio input.
- `i_ref_clk`  in  1: muxed reference clock; all state updates on its rising edge.
- `i_rst_n`  in  1: asynchronous active-low reset.
- `i_clk_en`  in  1: division enable.
- `i_div_ratio`  in  RATIO_WD: division ratio N; values 0 and 1 mean bypass.
- `o_div_clk`  out  1: divided clock, or `i_ref_clk` in bypass.
- `o_tick`  out  1: one-ref-cycle pulse, registered, asserted on each divided-clock rising edge.
- `o_active`  out  1: high while the FSM is not IDLE.

## Operation
- `active_req = i_clk_en && (i_div_ratio >= 2)`.
- H = N>>1 (high-phase length); L = N - H (low-phase length). Odd N gives a longer low phase.
- FSM states: IDLE, HIGH, LOW.
  - Register `cnt` is RATIO_WD wide.
  - Register `ratio_l` holds the latched ratio.
  - Register `div_r` holds the divided-clock value.
- IDLE: `div_r`=0.
  - If `active_req`: latch `ratio_l`=N, go to HIGH, set `div_r`=1, `cnt`=H-1, pulse `o_tick`.
- HIGH:
  - If `cnt`==0: go to LOW, set `div_r`=0, `cnt`=L-1.
  - Otherwise decrement `cnt`.
- LOW:
  - If `cnt`≠0: decrement `cnt`.
  - If `cnt`==0 and `active_req`: re-latch `ratio_l` from `i_div_ratio`, go to HIGH, set `div_r`=1, `cnt`=H'-1, pulse `o_tick`.
  - If `cnt`==0 and not `active_req`: go to IDLE.
- Output select: `o_div_clk` = `i_ref_clk` when state==IDLE and not `active_req`; otherwise `div_r`.
- `i_div_ratio` changes mid-period are ignored until the LOW→HIGH boundary. The current period always completes with the old ratio.
- Deasserting `i_clk_en` mid-period: the current period finishes (HIGH then full LOW), then the FSM enters IDLE and the bypass is selected. No runt pulses.
- A ratio change into the 0/1 range mid-period is treated the same as a disable.

## Timing
- Reset values: state=IDLE, `cnt`=0, `ratio_l`=0, `div_r`=0, `o_tick`=0, `o_active`=0. `o_div_clk` follows `i_ref_clk` (bypass) while in reset.
- Reset assertion is asynchronous and acts immediately at any point, including mid-period. Release takes effect on the next rising edge.
- Latency from `active_req` high to `o_div_clk` rising: one ref edge (registered).
- Divided period is exactly N ref cycles: high for H cycles, low for L cycles.
  - N=2 → 1/1.
  - N=3 → 1/2.
  - N=255 → 127/128.
- `o_tick` is coincident with the `div_r` 0→1 edge and is exactly one ref cycle wide.
- `o_active` is registered and equals (state≠IDLE).

## Structure
- Shared package/header `clk_div_pkg` holds:
  - state encoding constants IDLE/HIGH/LOW (2-bit);
  - default `RATIO_WD`=8.
- The output bypass select is an instance of the existing 2:1 mux cell `mux2X1`:
  - `Function_mode` = `div_r`;
  - `Test_mode` = `i_ref_clk`;
  - `sel` = bypass condition.

  This keeps clock muxing in a single DFT-reviewed cell.
- No other sub-modules.

## Test plan
- **Reset/bypass:** hold `i_rst_n`=0, N=4, `i_clk_en`=1 → `o_div_clk` tracks `i_ref_clk`, `o_tick`=0, `o_active`=0. Release reset → first `o_div_clk` rise one edge later.
- **Even/odd ratios:** N=4 → 2 high / 2 low, repeating. N=5 → 2 high / 3 low. `o_tick` pulses every 4 (resp. 5) ref cycles. Check over 10 periods.
- **Ratio change mid-period:** N=6 running; switch to N=3 at the 2nd HIGH cycle → the current period completes as 3/3, then 1/2 periods follow.
- **Disable mid-HIGH:** N=8, drop `i_clk_en` during HIGH → the remaining HIGH plus 4 LOW cycles complete, then `o_active`=0 and bypass is selected with no pulse shorter than one ref cycle.
- **Reset mid-operation:** N=7, assert `i_rst_n`=0 during LOW → all registers are 0 immediately. Re-release with N=2 → 1/1 toggling resumes.
- **Boundary ratios:** N=1 and N=0 with `i_clk_en`=1 → pure bypass, `o_active`=0. N=255 → 127 high / 128 low.
